bcd_to_bin: RTL and testbench

BCD_TO_BIN -- requirements
Module: bcd_to_bin

---
 rtl/bcd_pkg.sv | 24 ++
 rtl/mul10_add.sv | 26 ++
 rtl/bcd_to_bin.sv | 146 ++++++++++++++
 tb/tb_bcd_to_bin.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared FSM state encoding and default sizing constants for
//                the BCD-to-binary converter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    // Default number of BCD digits and the matching binary result width
    localparam int c_DEFAULT_DIGITS = 4;
    localparam int c_DEFAULT_RES_W  = 14;

    // Converter control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mul10_add.sv
// ============================================================================
//  Module      : mul10_add
//  Description : Combinational acc*10 + digit step built from shifts and
//                adds, truncated to RES_W bits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul10_add #(
    parameter int RES_W = 14
) (
    input  logic [RES_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [RES_W-1:0] result
);

    logic [RES_W-1:0] w_digit_ext;

    assign w_digit_ext = {{(RES_W-4){1'b0}}, digit};

    // acc*8 + acc*2 + digit; overflow wraps modulo 2^RES_W
    assign result = (acc << 3) + (acc << 1) + w_digit_ext;

endmodule

`default_nettype wire

// File: rtl/bcd_to_bin.sv
// ============================================================================
//  Module      : bcd_to_bin
//  Description : Sequential BCD-to-binary converter, one digit per clock,
//                most significant digit first.
//                Optional feature macro: BCD_DIGIT_CHECK_EN (flags digits
//                above 9 and zeroes the result of such a conversion).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = c_DEFAULT_DIGITS,
    parameter int RES_W  = c_DEFAULT_RES_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic [RES_W-1:0]      binary,
    output logic                  done,
    output logic                  busy,
    output logic                  err
);

    localparam int c_CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t               r_state;
    state_t               w_state_next;
    logic [4*DIGITS-1:0]  r_bcd;
    logic [RES_W-1:0]     r_acc;
    logic [RES_W-1:0]     r_binary;
    logic [RES_W-1:0]     w_next_acc;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [3:0]           w_digit;
    logic                 w_last;

    // Select the digit addressed by the counter
    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_cnt == c_CNT_W'(i)) begin
                w_digit = r_bcd[4*i +: 4];
            end
        end
    end

    assign w_last = (r_cnt == '0);

    mul10_add #(
        .RES_W (RES_W)
    ) u_mul10_add (
        .acc    (r_acc),
        .digit  (w_digit),
        .result (w_next_acc)
    );

`ifdef BCD_DIGIT_CHECK_EN
    logic r_flag;
    logic r_err;
    logic w_bad;
    logic w_flag_final;

    assign w_bad        = (w_digit > 4'd9);
    assign w_flag_final = r_flag | w_bad;
    assign err          = r_err;
`else
    assign err = 1'b0;
`endif

    assign binary = r_binary;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start only matters in IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: w_state_next = start  ? ST_RUN  : ST_IDLE;
            ST_RUN:  w_state_next = w_last ? ST_DONE : ST_RUN;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        done = (r_state == ST_DONE);
        busy = (r_state != ST_IDLE);
    end

    // Datapath: latch operand, accumulate digits, register the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd    <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_binary <= '0;
`ifdef BCD_DIGIT_CHECK_EN
            r_flag   <= 1'b0;
            r_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bcd  <= bcd;
                        r_acc  <= '0;
                        r_cnt  <= c_CNT_W'(DIGITS - 1);
`ifdef BCD_DIGIT_CHECK_EN
                        r_flag <= 1'b0;
                        r_err  <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    r_acc <= w_next_acc;
                    r_cnt <= r_cnt - c_CNT_W'(1);
`ifdef BCD_DIGIT_CHECK_EN
                    r_flag <= w_flag_final;
                    if (w_last) begin
                        r_binary <= w_flag_final ? '0 : w_next_acc;
                        r_err    <= w_flag_final;
                    end
`else
                    if (w_last) begin
                        r_binary <= w_next_acc;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
// ============================================================================
//  Module      : tb_bcd_to_bin
//  Description : Scoreboard bench for bcd_to_bin with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_bin;

    localparam int DIGITS = 4;
    localparam int RES_W  = 14;

    typedef struct {
        logic [RES_W-1:0] bin;
        logic             err;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [4*DIGITS-1:0]  bcd;
    logic [RES_W-1:0]     binary;
    logic                 done;
    logic                 busy;
    logic                 err;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   n_pushed = 0;

    bcd_to_bin #(
        .DIGITS (DIGITS),
        .RES_W  (RES_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bcd    (bcd),
        .binary (binary),
        .done   (done),
        .busy   (busy),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [RES_W-1:0] b, input logic e);
        exp_t x;
        x.bin = b;
        x.err = e;
        q_exp.push_back(x);
        n_pushed++;
    endtask

    // Monitor: every done pulse is matched against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t x;
            n_done++;
            if (q_exp.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                x = q_exp.pop_front();
                chk("binary", 32'(binary), 32'(x.bin));
                chk("err", 32'(err), 32'(x.err));
                chk("busy_with_done", 32'(busy), 32'd1);
            end
        end
    end

    // Issue one conversion and measure edges from accept to done
    task automatic convert(input logic [15:0] v, input logic [RES_W-1:0] eb,
                           input logic ee, input string name);
        int n;
        bit seen;
        @(negedge clk);
        bcd   = v;
        start = 1'b1;
        push_exp(eb, ee);
        @(posedge clk);
        #1 start = 1'b0;
        n    = 1;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            n++;
        end
        if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
        else       chk({name, "_latency"}, 32'(n), 32'(DIGITS + 1));
    endtask

    initial begin
        int seen;
        int cyc;
        int last;
        int lowcnt;

        rst_n = 1'b0;
        start = 1'b0;
        bcd   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_binary", 32'(binary), 32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_err",    32'(err),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        convert(16'h0006, 14'd6,    1'b0, "c0006");
        #1 chk("binary_hold", 32'(binary), 32'd6);
        convert(16'h9999, 14'h270F, 1'b0, "c9999");

        // Held start: back-to-back conversions every DIGITS+2 cycles
        @(negedge clk);
        bcd   = 16'h1234;
        start = 1'b1;
        repeat (3) push_exp(14'd1234, 1'b0);
        seen = 0; cyc = 0; last = 0; lowcnt = 0;
        for (int k = 0; k < 60 && seen < 3; k++) begin
            @(negedge clk);
            cyc++;
            if (!busy) lowcnt++;
            if (done) begin
                if (seen > 0) begin
                    chk("held_period",   32'(cyc - last), 32'(DIGITS + 2));
                    chk("held_busy_low", 32'(lowcnt),     32'd1);
                end
                last   = cyc;
                lowcnt = 0;
                seen++;
                if (seen == 3) start = 1'b0;
            end
        end
        if (seen < 3) chk("held_timeout", 32'(seen), 32'd3);
        repeat (3) @(negedge clk);
        chk("held_idle", 32'(busy), 32'd0);

        // Reset in the second RUN cycle aborts the conversion
        @(negedge clk);
        bcd   = 16'h5678;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_binary", 32'(binary), 32'd0);
        chk("abort_busy",   32'(busy),   32'd0);
        chk("abort_done",   32'(done),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        convert(16'h0042, 14'd42, 1'b0, "c0042");

        // Digit check behaviour
`ifdef BCD_DIGIT_CHECK_EN
        convert(16'h12A4, 14'd0, 1'b1, "c12A4");
`else
        convert(16'h12A4, 14'd1304, 1'b0, "c12A4");
`endif
        convert(16'h0010, 14'd10, 1'b0, "c0010");

        // Input changes and start pulses during RUN are ignored
        @(negedge clk);
        bcd   = 16'h0100;
        start = 1'b1;
        push_exp(14'd100, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        bcd   = 16'h9999;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);

        chk("scoreboard_empty", 32'(q_exp.size()), 32'd0);
        chk("done_count",       32'(n_done),       32'(n_pushed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
